dcsk_corr_accum: RTL and testbench

//   DCSK receiver correlation stage, directly downstream of the radix-4 Booth multiplier.
//   - Input: one signed product per sample (reference chip x information chip).
//   - Accumulates SPREAD_LEN products per symbol, then emits the correlation sum and the bit decision.

---
 rtl/dcsk_corr_accum.sv | 105 ++++++++++
 tb/tb_dcsk_corr_accum.sv | 204 ++++++++++++++++++++
 2 files changed

// File: rtl/dcsk_corr_accum.sv
// rtl/dcsk_corr_accum.sv - DCSK correlation accumulator: sums SPREAD_LEN products per symbol, decides the bit
module dcsk_corr_accum #(
  parameter int WORD_LEN   = 8,
  parameter int SPREAD_LEN = 16
) (
  input  logic                                     i_clk,
  input  logic                                     i_rst,
  input  logic                                     i_valid,
  input  logic [2*WORD_LEN-1:0]                    i_product,
  input  logic                                     i_clear,
  output logic                                     o_valid,
  output logic [2*WORD_LEN+$clog2(SPREAD_LEN)-1:0] o_acc,
  output logic                                     o_bit,
  output logic                                     o_busy,
  output logic [$clog2(SPREAD_LEN)-1:0]            o_sample_cnt
);

  localparam int PROD_W  = 2 * WORD_LEN;
  localparam int CNT_W   = $clog2(SPREAD_LEN);
  localparam int ACC_LEN = PROD_W + CNT_W;
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(SPREAD_LEN - 1);

  typedef enum logic {
    IDLE  = 1'b0,
    ACCUM = 1'b1
  } state_t;

  state_t               state_q, state_d;
  logic [CNT_W-1:0]     cnt_q, cnt_d;
  logic [ACC_LEN-1:0]   sum_q, sum_d;
  logic [ACC_LEN-1:0]   acc_q, acc_d;
  logic                 bit_q, bit_d;
  logic                 valid_q, valid_d;
  logic [ACC_LEN-1:0]   prod_ext;
  logic [ACC_LEN-1:0]   sum_next;

  assign prod_ext = {{(ACC_LEN-PROD_W){i_product[PROD_W-1]}}, i_product};
  // A symbol always starts from zero so a stale partial sum can never leak in.
  assign sum_next = ((state_q == IDLE) ? '0 : sum_q) + prod_ext;

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      sum_q   <= '0;
      acc_q   <= '0;
      bit_q   <= 1'b0;
      valid_q <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      sum_q   <= sum_d;
      acc_q   <= acc_d;
      bit_q   <= bit_d;
      valid_q <= valid_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    sum_d   = sum_q;
    acc_d   = acc_q;
    bit_d   = bit_q;
    valid_d = 1'b0;
    if (i_clear) begin
      state_d = IDLE;
      cnt_d   = '0;
      sum_d   = '0;
    end else if (i_valid) begin
      case (state_q)
        IDLE: begin
          state_d = ACCUM;
          cnt_d   = CNT_W'(1);
          sum_d   = sum_next;
        end
        ACCUM: begin
          if (cnt_q == LAST_CNT) begin
            state_d = IDLE;
            cnt_d   = '0;
            sum_d   = '0;
            acc_d   = sum_next;
            bit_d   = ~sum_next[ACC_LEN-1];
            valid_d = 1'b1;
          end else begin
            cnt_d = cnt_q + 1'b1;
            sum_d = sum_next;
          end
        end
        default: begin
          state_d = IDLE;
          cnt_d   = '0;
          sum_d   = '0;
        end
      endcase
    end
  end

  assign o_valid      = valid_q;
  assign o_acc        = acc_q;
  assign o_bit        = bit_q;
  assign o_busy       = (state_q == ACCUM);
  assign o_sample_cnt = cnt_q;

endmodule

// File: tb/tb_dcsk_corr_accum.sv
// tb/tb_dcsk_corr_accum.sv - scoreboard bench for dcsk_corr_accum (WORD_LEN=8, SPREAD_LEN=4)
module tb_dcsk_corr_accum;

  localparam int WORD_LEN   = 8;
  localparam int SPREAD_LEN = 4;
  localparam int ACC_LEN    = 18;

  logic                  clk;
  logic                  rst;
  logic                  valid_in;
  logic [2*WORD_LEN-1:0] product;
  logic                  clear;
  logic                  valid_out;
  logic [ACC_LEN-1:0]    acc;
  logic                  bit_out;
  logic                  busy;
  logic [1:0]            sample_cnt;

  typedef struct {
    longint acc;
    int     b;
    int     cyc;
  } exp_t;

  exp_t exp_q[$];
  int   checks   = 0;
  int   failures = 0;
  int   cyc      = 0;

  dcsk_corr_accum #(
    .WORD_LEN  (WORD_LEN),
    .SPREAD_LEN(SPREAD_LEN)
  ) dut (
    .i_clk       (clk),
    .i_rst       (rst),
    .i_valid     (valid_in),
    .i_product   (product),
    .i_clear     (clear),
    .o_valid     (valid_out),
    .o_acc       (acc),
    .o_bit       (bit_out),
    .o_busy      (busy),
    .o_sample_cnt(sample_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input longint act, input longint exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Monitor: every result pulse must match the next queued expectation.
  always @(negedge clk) begin
    if (valid_out === 1'b1) begin
      exp_t e;
      if (exp_q.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL unexpected_valid: got o_valid=1 with acc %0d expected no result (cycle %0d)",
                 $signed(acc), cyc);
      end else begin
        e = exp_q.pop_front();
        chk("o_acc", longint'($signed(acc)), e.acc);
        chk("o_bit", longint'(bit_out), longint'(e.b));
        chk("valid_cycle", longint'(cyc), longint'(e.cyc));
      end
    end
  end

  task automatic step(input logic v, input int p, input logic c);
    valid_in = v;
    product  = 16'(p);
    clear    = c;
    @(posedge clk);
    #1;
  endtask

  task automatic smp(input int p);
    step(1'b1, p, 1'b0);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(1'b0, 0, 1'b0);
  endtask

  // Call immediately before driving the symbol's final sample.
  task automatic expect_result(input longint a, input int b);
    exp_t e;
    e.acc = a;
    e.b   = b;
    e.cyc = cyc + 1;
    exp_q.push_back(e);
  endtask

  initial begin
    rst      = 1'b1;
    valid_in = 1'b0;
    product  = '0;
    clear    = 1'b0;
    @(posedge clk);
    #1;

    // 1. reset state
    idle(2);
    rst = 1'b0;
    idle(2);
    chk("reset_o_valid", longint'(valid_out), 0);
    chk("reset_o_acc", longint'(acc), 0);
    chk("reset_o_bit", longint'(bit_out), 0);
    chk("reset_o_busy", longint'(busy), 0);
    chk("reset_sample_cnt", longint'(sample_cnt), 0);

    // 2. basic symbol
    smp(100);
    smp(-20);
    chk("mid_busy", longint'(busy), 1);
    chk("mid_sample_cnt", longint'(sample_cnt), 2);
    smp(50);
    expect_result(133, 1);
    smp(3);
    idle(2);
    chk("after_busy", longint'(busy), 0);
    chk("after_sample_cnt", longint'(sample_cnt), 0);
    chk("hold_o_acc", longint'($signed(acc)), 133);

    // 3. extremes
    for (int i = 0; i < 3; i++) smp(-32768);
    expect_result(-131072, 0);
    smp(-32768);
    for (int i = 0; i < 3; i++) smp(16384);
    expect_result(65536, 1);
    smp(16384);
    idle(2);

    // 4. gaps: samples on relative cycles 0,3,4,9
    smp(5);
    idle(2);
    smp(-7);
    chk("gap_sample_cnt", longint'(sample_cnt), 2);
    smp(9);
    idle(4);
    chk("gap_busy_hold", longint'(busy), 1);
    expect_result(0, 1);
    smp(-7);
    idle(2);
    chk("gap_busy_after", longint'(busy), 0);

    // 5. clear, then clear colliding with a valid sample
    smp(7);
    smp(7);
    step(1'b0, 0, 1'b1);
    chk("clear_busy", longint'(busy), 0);
    chk("clear_sample_cnt", longint'(sample_cnt), 0);
    chk("clear_keeps_acc", longint'($signed(acc)), 0);
    for (int i = 0; i < 3; i++) smp(1);
    expect_result(4, 1);
    smp(1);
    smp(7);
    smp(7);
    step(1'b1, 100, 1'b1);
    for (int i = 0; i < 3; i++) smp(1);
    expect_result(4, 1);
    smp(1);
    // clear on the completing sample: no result
    for (int i = 0; i < 3; i++) smp(-50);
    step(1'b1, -50, 1'b1);
    idle(2);
    chk("clear_last_acc", longint'($signed(acc)), 4);
    chk("clear_last_busy", longint'(busy), 0);

    // 6. back-to-back symbols
    for (int i = 0; i < 3; i++) smp(10);
    expect_result(40, 1);
    smp(10);
    for (int i = 0; i < 3; i++) smp(-3);
    expect_result(-12, 0);
    smp(-3);
    idle(2);

    // 7. reset mid-symbol
    for (int i = 0; i < 3; i++) smp(9);
    rst = 1'b1;
    idle(1);
    rst = 1'b0;
    chk("midrst_acc", longint'(acc), 0);
    chk("midrst_sample_cnt", longint'(sample_cnt), 0);
    for (int i = 0; i < 3; i++) smp(2);
    expect_result(8, 1);
    smp(2);
    idle(4);

    chk("pending_results", longint'(exp_q.size()), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
